// File: rtl/imem_pkg.sv
// Shared widths and the owner encoding for the instruction memory arbiter.
// Pure declarations; no latency or flow control.
// Imported by imem_arbiter and by anything that decodes its owner register.
package imem_pkg;

  localparam int ADDR_W = 30;
  localparam int INST_W = 32;

  // Records which port received the grant so the response can be steered.
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DEBUG = 1'b1
  } owner_e;

endpackage

// File: rtl/imem_arbiter.sv
// Arbitrates a fetch port and a debug port onto one single-port instruction ROM.
// Latency: grant in cycle N, valid pulse and data for that port in cycle N+1.
// Backpressure: requesters hold req and addr until their combinational gnt; debug is starvation-bounded.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   f_req/f_addr/f_gnt  fetch request, word address, grant
//   f_valid/f_inst      fetch response pulse and instruction word
//   d_req/d_addr/d_gnt  debug request, word address, grant
//   d_valid/d_inst      debug response pulse and instruction word
//   rom_addr/rom_inst   ROM word address (ROM registers it) and read data one cycle later
module imem_arbiter
  import imem_pkg::*;
#(
  // Max consecutive fetch grants while debug is waiting (1..255).
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [INST_W-1:0] f_inst,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [INST_W-1:0] d_inst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]        starve_cnt;
  logic              starved;
  logic              resp_v;
  owner_e            owner_r;
  logic [ADDR_W-1:0] rom_addr_q;

  // Debug wins when fetch is idle, or when fetch has held it off STARVE_MAX times.
  // Grants are forced low during reset so a grant in the reset cycle never produces a response.
  assign starved = (starve_cnt == STARVE_LIM);
  assign d_gnt   = !rst && d_req && (!f_req || starved);
  assign f_gnt   = !rst && f_req && !d_gnt;

  // The ROM samples rom_addr every cycle; with no grant keep presenting the last address
  // so the ROM input does not toggle needlessly.
  always_comb begin
    if (rst) begin
      rom_addr = '0;
    end else if (f_gnt) begin
      rom_addr = f_addr;
    end else if (d_gnt) begin
      rom_addr = d_addr;
    end else begin
      rom_addr = rom_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      resp_v     <= 1'b0;
      owner_r    <= OWN_FETCH;
      rom_addr_q <= '0;
    end else begin
      resp_v     <= f_gnt || d_gnt;
      rom_addr_q <= rom_addr;
      if (d_gnt) begin
        owner_r <= OWN_DEBUG;
      end else if (f_gnt) begin
        owner_r <= OWN_FETCH;
      end
      // Counter only tracks an uninterrupted wait; any debug service or withdrawal restarts it.
      if (d_gnt || !d_req) begin
        starve_cnt <= '0;
      end else if (f_gnt && (starve_cnt < STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

  // Data is shared; only the valid of the recorded owner qualifies it.
  assign f_valid = !rst && resp_v && (owner_r == OWN_FETCH);
  assign d_valid = !rst && resp_v && (owner_r == OWN_DEBUG);
  assign f_inst  = rom_inst;
  assign d_inst  = rom_inst;

endmodule
